op_issue_fifo: RTL and testbench
================================

Name: op_issue_fifo

Overview:
- Upstream feeder for the registered +1 / pass / -1 arithmetic stage. That stage samples number/select every clk, has no valid input, and holds its result for select 2'b11.
- Buffers operand/opcode commands arriving on a valid/ready interface in a small FIFO and issues at most one command per cycle.
- Drives select=2'b11 (downstream hold) whenever nothing is issued.
- Rejects illegal opcode 2'b11 on input and counts it.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous FIFO clear.
- pause  input  1  downstream back-pressure; no issue while high.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid && in_ready.
- in_op  input  2  00 = +1, 01 = pass, 10 = -1, 11 = illegal.
- in_data  input  8  operand.
- number  output  8  registered operand to downstream.
- select  output  2  registered opcode to downstream; 2'b11 = hold.
- issue  output  1  registered one-cycle pulse per real issue.
- level  output  AW+1  registered FIFO occupancy, 0..DEPTH.
- err_cnt  output  8  illegal-opcode count, saturating.

Behaviour:
- Reset (RST low, asynchronous): pointers 0, level 0, number 8'h00, select 2'b11, issue 0, err_cnt 0.
- in_ready = (level != DEPTH), combinational from the registered level only. No push when full, even if a pop happens in the same cycle.
- Accept: in_valid && in_ready && !flush.
  - Legal op: write {in_op, in_data} at the write pointer.
  - in_op == 2'b11: entry dropped; err_cnt += 1, saturating at 8'hFF.
- Issue condition: !pause && !flush && level != 0.
  - Issue true: pop head; number <= head data; select <= head op; issue <= 1.
  - Otherwise: select <= 2'b11; number holds; issue <= 0.
- Latency: command accepted at edge N appears on number/select at edge N+1 at the earliest. Downstream result follows at N+2.
- Empty FIFO with push in the same cycle: no bypass, the FIFO is written; issue happens no earlier than the next edge.
- Push and pop in the same cycle when 0 < level < DEPTH: both occur and level is unchanged.
- Full: in_ready = 0, in_valid is ignored, err_cnt is unaffected.
- Pointers wrap modulo DEPTH. level tracks true occupancy: +1 push only, -1 pop only.
- flush = 1:
  - Pointers and level <= 0; select <= 2'b11; issue <= 0.
  - Any input presented this cycle is discarded, legal or illegal, and err_cnt is unchanged.
  - number holds. in_ready is still driven from the old level.
- pause = 1: FIFO contents are kept, pushes continue up to full, select = 2'b11 from the next edge.
- Ordering: strict FIFO. Illegal commands never reach the output.
- Reset asserted mid-stream: all state is cleared immediately; no partial issue completes.

Optional Feature:
- Macro: OP_ISSUE_BYPASS_EN.
- Defined: when level == 0, !pause, !flush, and a legal accept occurs, the command is loaded directly into number/select with issue = 1 at that same edge. The FIFO is not written and level stays 0. Latency is accept edge N to output at edge N. Illegal ops still only increment err_cnt.
- Undefined: no bypass; latency is always at least one extra edge, as in Behaviour.

Test Plan:
- Reset, then idle 3 cycles -> number 8'h00, select 2'b11, issue 0, level 0, in_ready 1, err_cnt 0.
- Push {00,8'h10}, {01,8'h20}, {10,8'h30} on consecutive edges, pause 0 -> select/number 00/10, 01/20, 10/30 on edges N+1..N+3, issue high 3 cycles, then select 2'b11.
- pause 1, push 5 legal ops with DEPTH 4 -> in_ready falls after 4 accepts, level 4, 5th held. Release pause -> 4 issues in order, 5th accepted once not full.
- Push {11,8'hAA} 300 times -> err_cnt 8'hFF (saturates), level 0, no issue pulses.
- Fill 3 entries under pause, assert flush together with a push of {00,8'h55} -> level 0, select 2'b11, no issue after pause drops; the 8'h55 command is lost.
- With OP_ISSUE_BYPASS_EN, empty FIFO, push {00,8'h7F} at edge N -> number 8'h7F, select 00, issue 1 at edge N, level stays 0. Without the macro, the same stimulus gives the output at edge N+1.

Source files
------------

// File: rtl/op_issue_fifo.sv
// Command FIFO feeding the registered +1 / pass / -1 stage; drives select=2'b11 (hold) when idle.
// Optional same-edge bypass into an empty FIFO is enabled by defining OP_ISSUE_BYPASS_EN.
module op_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          flush,
    input  logic          pause,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [7:0]    in_data,
    output logic [7:0]    number,
    output logic [1:0]    select,
    output logic          issue,
    output logic [AW:0]   level,
    output logic [7:0]    err_cnt
);

    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ZERO_LVL = {(AW + 1){1'b0}};
    localparam logic [AW:0]   ONE_LVL  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_PTR  = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [1:0]    OP_HOLD  = 2'b11;

    logic [9:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;

    logic       accept_s;
    logic       legal_s;
    logic       byp_s;
    logic       push_s;
    logic       pop_s;
    logic       err_inc_s;
    logic [9:0] head_s;

    // Ready depends only on the registered occupancy, so a same-cycle pop never frees a slot.
    assign in_ready = (level != FULL_LVL);

    // Handshake decode: accept, FIFO push, issue pop and illegal-op detection.
    always_comb begin
        accept_s  = 1'b0;
        legal_s   = 1'b0;
        byp_s     = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        err_inc_s = 1'b0;
        head_s    = mem_r[rd_ptr_r];

        accept_s = in_valid && in_ready && !flush;
        legal_s  = (in_op != OP_HOLD);
`ifdef OP_ISSUE_BYPASS_EN
        byp_s    = accept_s && legal_s && (level == ZERO_LVL) && !pause;
`else
        byp_s    = 1'b0;
`endif
        push_s    = accept_s && legal_s && !byp_s;
        err_inc_s = accept_s && !legal_s;
        pop_s     = !pause && !flush && (level != ZERO_LVL);
    end

    // Entry storage; no reset needed since level gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_op, in_data};
        end
    end

    // Pointers, occupancy and registered downstream outputs.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level    <= ZERO_LVL;
            number   <= 8'h00;
            select   <= OP_HOLD;
            issue    <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level    <= ZERO_LVL;
            select   <= OP_HOLD;
            issue    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end

            case ({push_s, pop_s})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase

            // pop_s and byp_s are exclusive: bypass only happens with an empty FIFO.
            if (pop_s) begin
                number <= head_s[7:0];
                select <= head_s[9:8];
                issue  <= 1'b1;
            end else if (byp_s) begin
                number <= in_data;
                select <= in_op;
                issue  <= 1'b1;
            end else begin
                select <= OP_HOLD;
                issue  <= 1'b0;
            end
        end
    end

    // Saturating illegal-opcode counter; flush already suppresses accept_s.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            err_cnt <= 8'h00;
        end else if (err_inc_s && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_op_issue_fifo.sv
// Directed bench for op_issue_fifo; expectations adapt to OP_ISSUE_BYPASS_EN when defined.
module tb_op_issue_fifo;

`ifdef OP_ISSUE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic       clk = 1'b0;
    logic       RST;
    logic       flush;
    logic       pause;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic [7:0] number;
    logic [1:0] select;
    logic       issue;
    logic [2:0] level;
    logic [7:0] err_cnt;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    op_issue_fifo #(.DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .RST      (RST),
        .flush    (flush),
        .pause    (pause),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_data  (in_data),
        .number   (number),
        .select   (select),
        .issue    (issue),
        .level    (level),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] d);
        in_valid = v;
        in_op    = op;
        in_data  = d;
    endtask

    logic [1:0] t2_sel [6];
    logic [7:0] t2_num [6];
    logic       t2_iss [6];
    logic [1:0] t3_op  [5];
    logic [7:0] t3_dat [5];
    int         issue_seen;

    initial begin
        RST = 1'b0; flush = 1'b0; pause = 1'b0;
        drive(1'b0, 2'b00, 8'h00);

        // Reset and idle
        tick(); tick();
        RST = 1'b1;
        tick(); tick(); tick();
        chk("rst_number", 16'(number), 16'h00);
        chk("rst_select", 16'(select), 16'h3);
        chk("rst_issue", 16'(issue), 16'h0);
        chk("rst_level", 16'(level), 16'h0);
        chk("rst_ready", 16'(in_ready), 16'h1);
        chk("rst_err", 16'(err_cnt), 16'h00);

        // Three consecutive pushes; bypass shifts the output one edge earlier
        t2_sel = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        t2_num = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h30, 8'h30};
        t2_iss = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1'b1, 2'b00, 8'h10);
                1: drive(1'b1, 2'b01, 8'h20);
                2: drive(1'b1, 2'b10, 8'h30);
                default: drive(1'b0, 2'b00, 8'h00);
            endcase
            tick();
            chk($sformatf("seq_sel_%0d", i), 16'(select), 16'(t2_sel[i + BYP]));
            chk($sformatf("seq_num_%0d", i), 16'(number), 16'(t2_num[i + BYP]));
            chk($sformatf("seq_iss_%0d", i), 16'(issue), 16'(t2_iss[i + BYP]));
        end
        chk("seq_level_end", 16'(level), 16'h0);

        // Fill under pause; fifth command must wait for a free slot
        t3_op  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
        t3_dat = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t3_op[i], t3_dat[i]);
            tick();
            chk($sformatf("fill_level_%0d", i), 16'(level), 16'(i + 1));
        end
        drive(1'b1, t3_op[4], t3_dat[4]);
        chk("full_ready", 16'(in_ready), 16'h0);
        chk("full_select", 16'(select), 16'h3);
        chk("full_issue", 16'(issue), 16'h0);
        tick();
        chk("full_level_held", 16'(level), 16'h4);
        chk("full_ready_held", 16'(in_ready), 16'h0);
        pause = 1'b0;
        tick();
        chk("drain0_num", 16'(number), 16'h41);
        chk("drain0_sel", 16'(select), 16'h0);
        chk("drain0_level", 16'(level), 16'h3);
        chk("drain0_ready", 16'(in_ready), 16'h1);
        tick();
        drive(1'b0, 2'b00, 8'h00);
        chk("drain1_num", 16'(number), 16'h42);
        chk("drain1_sel", 16'(select), 16'h1);
        chk("drain1_level", 16'(level), 16'h3);
        for (int i = 2; i < 5; i++) begin
            tick();
            chk($sformatf("drain%0d_num", i), 16'(number), 16'(t3_dat[i]));
            chk($sformatf("drain%0d_sel", i), 16'(select), 16'(t3_op[i]));
            chk($sformatf("drain%0d_iss", i), 16'(issue), 16'h1);
            chk($sformatf("drain%0d_level", i), 16'(level), 16'(4 - i));
        end
        tick();
        chk("drain_done_sel", 16'(select), 16'h3);
        chk("drain_done_iss", 16'(issue), 16'h0);

        // Illegal opcode flood saturates the error counter
        issue_seen = 0;
        drive(1'b1, 2'b11, 8'hAA);
        tick();
        chk("err_first", 16'(err_cnt), 16'h01);
        for (int i = 1; i < 300; i++) begin
            tick();
            if (issue) issue_seen++;
        end
        drive(1'b0, 2'b00, 8'h00);
        chk("err_sat", 16'(err_cnt), 16'hFF);
        chk("err_level", 16'(level), 16'h0);
        chk("err_no_issue", 16'(issue_seen), 16'h0);

        // Flush with a simultaneous push discards everything
        pause = 1'b1;
        drive(1'b1, 2'b00, 8'h61); tick();
        drive(1'b1, 2'b01, 8'h62); tick();
        drive(1'b1, 2'b10, 8'h63); tick();
        chk("pre_flush_level", 16'(level), 16'h3);
        flush = 1'b1;
        drive(1'b1, 2'b00, 8'h55);
        chk("flush_ready_old", 16'(in_ready), 16'h1);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, 8'h00);
        chk("flush_level", 16'(level), 16'h0);
        chk("flush_select", 16'(select), 16'h3);
        chk("flush_err", 16'(err_cnt), 16'hFF);
        pause = 1'b0;
        issue_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (issue) issue_seen++;
        end
        chk("flush_no_issue", 16'(issue_seen), 16'h0);
        chk("flush_number_hold", 16'(number), 16'h45);
        chk("flush_level_after", 16'(level), 16'h0);

        // Single push into an empty FIFO: latency with and without bypass
        drive(1'b1, 2'b00, 8'h7F);
        tick();
        drive(1'b0, 2'b00, 8'h00);
        chk("lat_n_issue", 16'(issue), 16'(BYP));
        chk("lat_n_select", 16'(select), BYP ? 16'h0 : 16'h3);
        chk("lat_n_number", 16'(number), BYP ? 16'h7F : 16'h45);
        chk("lat_n_level", 16'(level), BYP ? 16'h0 : 16'h1);
        tick();
        chk("lat_n1_issue", 16'(issue), BYP ? 16'h0 : 16'h1);
        chk("lat_n1_select", 16'(select), BYP ? 16'h3 : 16'h0);
        chk("lat_n1_number", 16'(number), 16'h7F);
        chk("lat_n1_level", 16'(level), 16'h0);

        // Asynchronous reset in the middle of buffered traffic
        pause = 1'b1;
        drive(1'b1, 2'b10, 8'h91); tick();
        drive(1'b1, 2'b01, 8'h92); tick();
        drive(1'b0, 2'b00, 8'h00);
        chk("mid_level", 16'(level), 16'h2);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_level", 16'(level), 16'h0);
        chk("arst_select", 16'(select), 16'h3);
        chk("arst_number", 16'(number), 16'h00);
        chk("arst_err", 16'(err_cnt), 16'h00);
        chk("arst_ready", 16'(in_ready), 16'h1);
        tick();
        RST = 1'b1;
        pause = 1'b0;
        tick(); tick();
        chk("arst_no_issue", 16'(issue), 16'h0);
        chk("arst_level_after", 16'(level), 16'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
